// File: rtl/ex_mem_result_stage_if.sv
// EX->MEM stage bundle: EX drives the master side, the result stage is the slave.
// byp_z/v/n exist only when FLAG_BYPASS_EN is defined.
interface ex_mem_result_stage_if #(
  parameter int DW   = 16,
  parameter int RW   = 4,
  parameter int REDW = 7
);
  logic            stall;
  logic            flush;
  logic            in_valid;
  logic [3:0]      opcode;
  logic [DW-1:0]   alu_result;
  logic            alu_ovfl;
  logic [REDW-1:0] red_result;
  logic [RW-1:0]   dst_reg;
  logic            reg_wr_en;
  logic            mem_rd;
  logic            mem_wr;
  logic [DW-1:0]   mem_wdata;

  logic            out_valid;
  logic [DW-1:0]   out_result;
  logic [RW-1:0]   out_dst_reg;
  logic            out_reg_wr_en;
  logic            out_mem_rd;
  logic            out_mem_wr;
  logic [DW-1:0]   out_mem_wdata;
  logic            flag_z;
  logic            flag_v;
  logic            flag_n;
  logic            halted;
`ifdef FLAG_BYPASS_EN
  logic            byp_z;
  logic            byp_v;
  logic            byp_n;
`endif

  modport master (
    output stall, flush, in_valid, opcode, alu_result, alu_ovfl, red_result,
           dst_reg, reg_wr_en, mem_rd, mem_wr, mem_wdata,
    input  out_valid, out_result, out_dst_reg, out_reg_wr_en, out_mem_rd,
           out_mem_wr, out_mem_wdata, flag_z, flag_v, flag_n, halted
`ifdef FLAG_BYPASS_EN
    , input byp_z, byp_v, byp_n
`endif
  );

  modport slave (
    input  stall, flush, in_valid, opcode, alu_result, alu_ovfl, red_result,
           dst_reg, reg_wr_en, mem_rd, mem_wr, mem_wdata,
    output out_valid, out_result, out_dst_reg, out_reg_wr_en, out_mem_rd,
           out_mem_wr, out_mem_wdata, flag_z, flag_v, flag_n, halted
`ifdef FLAG_BYPASS_EN
    , output byp_z, byp_v, byp_n
`endif
  );
endinterface

// File: rtl/ex_mem_result_stage.sv
// EX->MEM result stage: result select, Z/V/N flag register, run/halt FSM; 1-cycle latency.
// flush squashes (beats stall), stall holds all state; FLAG_BYPASS_EN adds byp_z/v/n.
module ex_mem_result_stage #(
  parameter int DW   = 16,
  parameter int RW   = 4,
  parameter int REDW = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  ex_mem_result_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_is_hlt;
  logic [DW-1:0] w_result;
  logic          w_upd_zvn;
  logic          w_upd_z;
  logic          w_z_nxt;
  logic          w_v_nxt;
  logic          w_n_nxt;

  logic          r_valid;
  logic [DW-1:0] r_result;
  logic [RW-1:0] r_dst_reg;
  logic          r_reg_wr_en;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_z;
  logic          r_v;
  logic          r_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        w_accept = bus.in_valid & ~bus.stall & ~bus.flush;
        if (w_accept && (bus.opcode == OP_HLT)) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        w_accept    = 1'b0;
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign w_is_hlt = (bus.opcode == OP_HLT);
  assign w_result = (bus.opcode == OP_RED)
                  ? {{(DW-REDW){bus.red_result[REDW-1]}}, bus.red_result}
                  : bus.alu_result;

  // Next flag values double as the bypass view: they equal the register unless this cycle writes it.
  assign w_upd_zvn = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
  assign w_upd_z   = w_upd_zvn || (bus.opcode == OP_XOR) || (bus.opcode == OP_SLL)
                  || (bus.opcode == OP_SRA) || (bus.opcode == OP_ROR);
  assign w_z_nxt   = (w_accept && w_upd_z)   ? (w_result == '0)    : r_z;
  assign w_v_nxt   = (w_accept && w_upd_zvn) ? bus.alu_ovfl        : r_v;
  assign w_n_nxt   = (w_accept && w_upd_zvn) ? w_result[DW-1]      : r_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
      r_v <= 1'b0;
      r_n <= 1'b0;
    end else begin
      r_z <= w_z_nxt;
      r_v <= w_v_nxt;
      r_n <= w_n_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_dst_reg   <= '0;
      r_reg_wr_en <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
    end else if (bus.flush || (r_state == S_HALT)) begin
      r_valid     <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
    end else if (bus.stall) begin
      r_valid     <= r_valid;
    end else if (w_accept) begin
      // HLT travels to MEM as a valid bubble with no side effects.
      r_valid     <= 1'b1;
      r_result    <= w_result;
      r_dst_reg   <= bus.dst_reg;
      r_reg_wr_en <= bus.reg_wr_en & ~w_is_hlt;
      r_mem_rd    <= bus.mem_rd    & ~w_is_hlt;
      r_mem_wr    <= bus.mem_wr    & ~w_is_hlt;
      r_mem_wdata <= bus.mem_wdata;
    end else begin
      r_valid     <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_result    = r_result;
  assign bus.out_dst_reg   = r_dst_reg;
  assign bus.out_reg_wr_en = r_reg_wr_en;
  assign bus.out_mem_rd    = r_mem_rd;
  assign bus.out_mem_wr    = r_mem_wr;
  assign bus.out_mem_wdata = r_mem_wdata;
  assign bus.flag_z        = r_z;
  assign bus.flag_v        = r_v;
  assign bus.flag_n        = r_n;
  assign bus.halted        = (r_state == S_HALT);

`ifdef FLAG_BYPASS_EN
  assign bus.byp_z = w_z_nxt;
  assign bus.byp_v = w_v_nxt;
  assign bus.byp_n = w_n_nxt;
`endif

endmodule

// File: tb/tb_ex_mem_result_stage.sv
// Scoreboard bench for ex_mem_result_stage: expected output snapshots are queued with each stimulus
// and popped after the sampling point; snapshot = {valid,result,dst,wr_en,rd,wr,wdata,z,v,n,halted}.
module tb_ex_mem_result_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [43:0] sb[$];
  logic [43:0] e;
  logic [43:0] o;

  ex_mem_result_stage_if #(.DW(16), .RW(4), .REDW(7)) bus ();

  ex_mem_result_stage #(.DW(16), .RW(4), .REDW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] snap();
    return {bus.out_valid, bus.out_result, bus.out_dst_reg, bus.out_reg_wr_en,
            bus.out_mem_rd, bus.out_mem_wr, bus.out_mem_wdata,
            bus.flag_z, bus.flag_v, bus.flag_n, bus.halted};
  endfunction

  function automatic logic [43:0] mk(input logic v, input logic [15:0] r, input logic [3:0] d,
                                     input logic we, input logic rd, input logic wr,
                                     input logic [15:0] wd, input logic z, input logic vf,
                                     input logic n, input logic h);
    return {v, r, d, we, rd, wr, wd, z, vf, n, h};
  endfunction

  task automatic drive(input logic vld, input logic [3:0] op, input logic [15:0] alu,
                       input logic ovfl, input logic [6:0] red, input logic [3:0] dst,
                       input logic we, input logic rd, input logic wr, input logic [15:0] wd,
                       input logic stl, input logic fl);
    bus.in_valid   = vld;
    bus.opcode     = op;
    bus.alu_result = alu;
    bus.alu_ovfl   = ovfl;
    bus.red_result = red;
    bus.dst_reg    = dst;
    bus.reg_wr_en  = we;
    bus.mem_rd     = rd;
    bus.mem_wr     = wr;
    bus.mem_wdata  = wd;
    bus.stall      = stl;
    bus.flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 4'h0, 16'hFFFF, 1, 7'h7F, 4'hF, 1, 1, 1, 16'hFFFF, 0, 0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); o = snap(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset[%0d]: got=%h want=%h", i, o, e); end
    end
    rst_n = 1'b1;
    drive(0, 4'h0, 16'h0, 0, 7'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic test_red();
    drive(1, 4'h3, 16'h1234, 1, 7'h40, 4'h3, 1, 0, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'hFFC0, 4'h3, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL red_neg: got=%h want=%h", o, e); end

    drive(1, 4'h3, 16'h1234, 1, 7'h15, 4'h5, 1, 0, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'h0015, 4'h5, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL red_pos: got=%h want=%h", o, e); end
  endtask

  task automatic test_add_xor();
    drive(1, 4'h0, 16'h7FFF, 1, 7'h7F, 4'h1, 1, 0, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'h7FFF, 4'h1, 1, 0, 0, 16'h0, 0, 1, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL add_ovfl: got=%h want=%h", o, e); end

    drive(1, 4'h2, 16'h0000, 0, 7'h0, 4'h2, 1, 0, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'h0000, 4'h2, 1, 0, 0, 16'h0, 1, 1, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL xor_zero: got=%h want=%h", o, e); end

    // invalid slot: controls drop, data and flags hold
    drive(0, 4'h0, 16'hFFFF, 0, 7'h0, 4'h9, 1, 1, 1, 16'h5A5A, 0, 0);
    sb.push_back(mk(0, 16'h0000, 4'h2, 0, 0, 0, 16'h0, 1, 1, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL idle: got=%h want=%h", o, e); end
  endtask

  task automatic test_stall();
    drive(1, 4'h1, 16'h8000, 0, 7'h0, 4'h6, 1, 0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(0, 16'h0000, 4'h2, 0, 0, 0, 16'h0, 1, 1, 0, 0));
      tick();
      e = sb.pop_front(); o = snap(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL stall_hold[%0d]: got=%h want=%h", i, o, e); end
    end
    bus.stall = 1'b0;
    sb.push_back(mk(1, 16'h8000, 4'h6, 1, 0, 0, 16'h0, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL stall_release: got=%h want=%h", o, e); end
  endtask

  task automatic test_flush_stall();
    drive(1, 4'h8, 16'h0010, 0, 7'h0, 4'h4, 1, 1, 0, 16'h0, 1, 1);
    sb.push_back(mk(0, 16'h8000, 4'h6, 0, 0, 0, 16'h0, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL flush_and_stall: got=%h want=%h", o, e); end

    // flush of a flag-writing op must not touch flags
    drive(1, 4'h0, 16'h0000, 1, 7'h0, 4'h4, 1, 0, 0, 16'h0, 0, 1);
    sb.push_back(mk(0, 16'h8000, 4'h6, 0, 0, 0, 16'h0, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL flush_only: got=%h want=%h", o, e); end

    drive(1, 4'h8, 16'h0010, 0, 7'h0, 4'h4, 1, 1, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'h0010, 4'h4, 1, 1, 0, 16'h0, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL load: got=%h want=%h", o, e); end

    drive(1, 4'h9, 16'h0020, 0, 7'h0, 4'h0, 0, 0, 1, 16'hABCD, 0, 0);
    sb.push_back(mk(1, 16'h0020, 4'h0, 0, 0, 1, 16'hABCD, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL store: got=%h want=%h", o, e); end
  endtask

  task automatic test_shift_flags();
    logic [3:0]  ops [6] = '{4'h4, 4'h5, 4'h6, 4'h2, 4'h7, 4'h3};
    logic [15:0] alus[6] = '{16'h0000, 16'h0001, 16'h0000, 16'h0005, 16'h0000, 16'hFFFF};
    logic [15:0] res [6] = '{16'h0000, 16'h0001, 16'h0000, 16'h0005, 16'h0000, 16'h0000};
    logic        zs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1, ops[i], alus[i], 1, 7'h00, 4'h7, 1, 0, 0, 16'h0, 0, 0);
      sb.push_back(mk(1, res[i], 4'h7, 1, 0, 0, 16'h0, zs[i], 0, 1, 0));
      tick();
      e = sb.pop_front(); o = snap(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL flag_op[%0d] op=%h: got=%h want=%h", i, ops[i], o, e); end
    end
  endtask

  task automatic test_halt();
    drive(1, 4'hF, 16'h5555, 0, 7'h0, 4'h8, 1, 1, 1, 16'h1111, 0, 0);
    sb.push_back(mk(1, 16'h5555, 4'h8, 0, 0, 0, 16'h1111, 0, 0, 1, 1));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL hlt_accept: got=%h want=%h", o, e); end

    drive(1, 4'h0, 16'h0000, 1, 7'h0, 4'h9, 1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 16'h5555, 4'h8, 0, 0, 0, 16'h1111, 0, 0, 1, 1));
      tick();
      e = sb.pop_front(); o = snap(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL halted_ignore[%0d]: got=%h want=%h", i, o, e); end
    end

    #3;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL async_reset: got=%h want=%h", o, e); end

    tick();
    rst_n = 1'b1;
    drive(1, 4'h0, 16'h0000, 0, 7'h0, 4'h9, 1, 0, 0, 16'h0, 0, 0);
    sb.push_back(mk(1, 16'h0000, 4'h9, 1, 0, 0, 16'h0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = snap(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL run_after_reset: got=%h want=%h", o, e); end
  endtask

`ifdef FLAG_BYPASS_EN
  task automatic test_bypass();
    drive(1, 4'h0, 16'h8000, 1, 7'h0, 4'h1, 1, 0, 0, 16'h0, 0, 0);
    tick();
    drive(1, 4'h1, 16'h0000, 0, 7'h0, 4'h1, 1, 0, 0, 16'h0, 0, 0);
    #1;
    n_cmp++;
    if ({bus.byp_z, bus.byp_v, bus.byp_n} !== 3'b100) begin
      n_err++; $display("FAIL byp_same_cycle: got=%b want=100", {bus.byp_z, bus.byp_v, bus.byp_n});
    end
    n_cmp++;
    if ({bus.flag_z, bus.flag_v, bus.flag_n} !== 3'b011) begin
      n_err++; $display("FAIL byp_reg_before: got=%b want=011", {bus.flag_z, bus.flag_v, bus.flag_n});
    end
    tick();
    n_cmp++;
    if ({bus.flag_z, bus.flag_v, bus.flag_n} !== 3'b100) begin
      n_err++; $display("FAIL byp_reg_after: got=%b want=100", {bus.flag_z, bus.flag_v, bus.flag_n});
    end
    drive(1, 4'h1, 16'h8000, 1, 7'h0, 4'h1, 1, 0, 0, 16'h0, 1, 0);
    #1;
    n_cmp++;
    if ({bus.byp_z, bus.byp_v, bus.byp_n} !== 3'b100) begin
      n_err++; $display("FAIL byp_stalled: got=%b want=100", {bus.byp_z, bus.byp_v, bus.byp_n});
    end
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_red();
    test_add_xor();
    test_stall();
    test_flush_stall();
    test_shift_flags();
    test_halt();
`ifdef FLAG_BYPASS_EN
    test_bypass();
`endif
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got=%0d left want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
